// File: rtl/lcd_cmd_sequencer_if.sv
// Host/downstream bundle for the LCD command sequencer: host write handshake plus
// the control/data words and strobe presented to the downstream LCD writer.
interface lcd_cmd_sequencer_if;
  logic        start;
  logic        cmd_rs;
  logic [7:0]  cmd_byte;
  logic        ready;
  logic        done;
  logic [31:0] instruction;
  logic [31:0] data;
  logic        en;

  modport master (
    output start, cmd_rs, cmd_byte,
    input  ready, done, instruction, data, en
  );

  modport slave (
    input  start, cmd_rs, cmd_byte,
    output ready, done, instruction, data, en
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style LCD sequencer: power-on wait, fixed init table, then one host byte
// at a time, each followed by the controller's required settle time.
module lcd_cmd_sequencer #(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLEAR   = 82000
) (
  input logic                clk,
  input logic                reset_n,
  lcd_cmd_sequencer_if.slave bus
);

  localparam int unsigned MaxWait = (T_POWERON > T_CLEAR) ? T_POWERON : T_CLEAR;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  typedef enum logic [2:0] {
    StPwrWait,
    StInitIssue,
    StInitWait,
    StIdle,
    StHostIssue,
    StHostWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            rs_q, rs_d;
  logic [7:0]      byte_q, byte_d;
  logic [CntW-1:0] wait_cur;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = 8'h38;
      3'd3:             b = 8'h0C;
      3'd4:             b = 8'h01;
      3'd5:             b = 8'h06;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear and return-home need the long settle time; everything else is short.
  function automatic logic [CntW-1:0] wait_len(input logic rs, input logic [7:0] b);
    if (!rs && (b == 8'h01 || b == 8'h02)) return CntW'(T_CLEAR);
    return CntW'(T_CMD);
  endfunction

  assign wait_cur = wait_len(rs_q, byte_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    byte_d  = byte_q;
    case (state_q)
      StPwrWait: begin
        if (cnt_q == CntW'(T_POWERON - 1)) begin
          state_d = StInitIssue;
          cnt_d   = '0;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          byte_d  = init_byte(3'd0);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StInitIssue: begin
        state_d = StInitWait;
        cnt_d   = '0;
      end
      StInitWait: begin
        // Exit one cycle early: the issue cycle makes en-to-en equal wait + 1.
        if (cnt_q == wait_cur - CntW'(1)) begin
          cnt_d = '0;
          if (idx_q == 3'd5) begin
            state_d = StIdle;
          end else begin
            state_d = StInitIssue;
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            byte_d  = init_byte(idx_q + 3'd1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        if (bus.start) begin
          state_d = StHostIssue;
          rs_d    = bus.cmd_rs;
          byte_d  = bus.cmd_byte;
        end
      end
      StHostIssue: begin
        state_d = StHostWait;
        cnt_d   = '0;
      end
      StHostWait: begin
        if (cnt_q == wait_cur) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StPwrWait;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StPwrWait;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      rs_q    <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      byte_q  <= byte_d;
    end
  end

  assign bus.ready       = (state_q == StIdle);
  assign bus.en          = (state_q == StInitIssue) || (state_q == StHostIssue);
  assign bus.done        = (state_q == StHostWait) && (cnt_q == wait_cur);
  assign bus.instruction = {31'b0, rs_q};
  assign bus.data        = {24'b0, byte_q};

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter T_POWERON, default 750000, meaning clock cycles waited after reset before the first init command (15 ms at 50 MHz).
REQ-002 The block SHALL have parameter T_CMD, default 2500, meaning clock cycles waited after issuing any ordinary command or data byte (50 us).
REQ-003 The block SHALL have parameter T_CLEAR, default 82000, meaning clock cycles waited after issuing byte 0x01 or 0x02 with rs=0 (1.64 ms).
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, meaning reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, meaning a host request to write one byte, sampled only while ready=1.
REQ-007 The block SHALL have port cmd_rs, input, 1, meaning the host register select (0 = command, 1 = character data).
REQ-008 The block SHALL have port cmd_byte, input, 8, meaning the host byte to write.
REQ-009 The block SHALL have port ready, output, 1, meaning the block is idle and accepts start.
REQ-010 The block SHALL have port done, output, 1, meaning a one-cycle pulse when a host write's wait period has completed.
REQ-011 The block SHALL have port instruction, output, 32, meaning the downstream writer control word; bit 0 is rs and bits 31:1 are 0.
REQ-012 The block SHALL have port data, output, 32, meaning the downstream writer data word; bits 7:0 are the byte and bits 31:8 are 0.
REQ-013 The block SHALL have port en, output, 1, meaning a one-cycle strobe that tells the downstream writer to latch instruction/data.

Function
REQ-014 The block SHALL implement states PWR_WAIT, INIT_ISSUE, INIT_WAIT, IDLE, HOST_ISSUE, HOST_WAIT.
REQ-015 PWR_WAIT SHALL count T_POWERON cycles, then go to INIT_ISSUE with init index 0.
REQ-016 The init table SHALL be, in order (all rs=0): 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
REQ-017 INIT_ISSUE SHALL drive instruction/data from the table entry, assert en for exactly one cycle, and go to INIT_WAIT.
REQ-018 INIT_WAIT SHALL count the wait for the issued byte (T_CLEAR for 0x01/0x02 with rs=0, else T_CMD). It SHALL then go to INIT_ISSUE with the next index, or to IDLE after index 5.
REQ-019 In IDLE, ready SHALL be 1; in every other state, ready SHALL be 0.
REQ-020 Start=1 in IDLE SHALL capture cmd_rs and cmd_byte that cycle and go to HOST_ISSUE.
REQ-021 HOST_ISSUE SHALL drive instruction[0]=captured rs and data[7:0]=captured byte, assert en for exactly one cycle, and go to HOST_WAIT.
REQ-022 HOST_WAIT SHALL count the wait per the REQ-018 rule.
REQ-023 On the final cycle of HOST_WAIT, done SHALL pulse for exactly one cycle and the state SHALL return to IDLE; ready SHALL rise on the next cycle.
REQ-024 Start while ready=0, including during the init sequence, SHALL be ignored and not queued.
REQ-025 Init-table writes SHALL never assert done.
REQ-026 instruction and data SHALL hold their last values between en strobes. The downstream writer latches them one cycle after en, so they SHALL stay stable for at least 2 cycles after en.
REQ-027 The wait counter SHALL be wide enough for max(T_POWERON, T_CLEAR) and SHALL NOT wrap. The wait length is exact: en to the next en (init), or en to done (host), equals the wait value plus 1 cycle.
REQ-028 Start asserted on the same cycle that the block enters IDLE (ready still 0) SHALL be ignored.

Reset
REQ-029 While reset_n=0, the state SHALL be PWR_WAIT with counter 0 and init index 0, and outputs SHALL be en=0, done=0, ready=0, instruction=0, data=0.
REQ-030 Reset asserted mid-sequence SHALL abort immediately; after release, the full power-on wait and init sequence SHALL restart.

Verification (T_POWERON=20, T_CMD=5, T_CLEAR=12)
REQ-031 Release reset_n -> first en 20 cycles after release with data=0x38, instruction=0.
REQ-032 Observe the full init -> exactly 6 en pulses with bytes 38,38,38,0C,01,06. The gap after 0x01 is 13 cycles and all other gaps are 6; ready=1 after the last wait; done is never asserted.
REQ-033 In IDLE, pulse start with cmd_rs=1 and cmd_byte=0x41 -> one en with instruction=1 and data=0x41, done 6 cycles after en, ready back to 1 the next cycle.
REQ-034 Host write with rs=0 and byte 0x01 -> done 13 cycles after en; rs=0 and byte 0x80 -> done 6 cycles after en.
REQ-035 Hold start=1 throughout init and a host write -> no extra en, and one write accepted per IDLE visit only.
REQ-036 Assert reset_n=0 during INIT_WAIT of index 3 -> outputs zero at once; after release, the sequence restarts from the 20-cycle wait and index 0.
